// File: rtl/sine_pkg.sv
// Shared constants and table generator for the quarter-wave sine ROM.
// The generator runs at elaboration only; it never reaches hardware.
package sine_pkg;

  localparam int SINE_ADDR_W = 13;
  localparam int SINE_DATA_W = 16;
  localparam int SINE_AMPL   = 32767;

  localparam real SINE_PI = 3.14159265358979323846;

  // Taylor series keeps this usable as a constant function everywhere;
  // eleven terms reach double precision over 0..pi/2.
  function automatic int sine_entry(
    input int k,
    input int aw,
    input int dw
  );
    real x;
    real term;
    real sum;
    real ampl;
    ampl = $itor((1 << (dw - 1)) - 1);
    x    = SINE_PI * $itor(k) / $itor(2 * (1 << aw));
    term = x;
    sum  = x;
    for (int i = 1; i < 12; i++) begin
      term = -term * x * x / $itor((2 * i) * (2 * i + 1));
      sum  = sum + term;
    end
    return $rtoi(ampl * sum + 0.5);
  endfunction

endpackage

// File: rtl/sine_rom.sv
// Registered quarter-wave sine lookup: constant ROM plus one output
// register, so amplitude trails the phase index by exactly one clock.
module sine_rom
  import sine_pkg::*;
#(
  parameter int ADDR_W = SINE_ADDR_W,
  parameter int DATA_W = SINE_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] v,
  output logic [DATA_W-1:0] sv
);

  localparam int N = 1 << ADDR_W;

  logic [DATA_W-1:0] w_rom [N];
  logic [DATA_W-1:0] r_sv;

  // Every entry is an elaboration-time constant.
  for (genvar g = 0; g < N; g++) begin : g_rom
    assign w_rom[g] = DATA_W'(sine_entry(g, ADDR_W, DATA_W));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sv <= '0;
    end else begin
      r_sv <= w_rom[v];
    end
  end

  assign sv = r_sv;

endmodule

// File: tb/tb_sine_rom.sv
// Bench for sine_rom: reset, key points, full sweep, alternation,
// folding pair, mid-stream reset and random lookups vs a $sin model.
module tb_sine_rom;

  logic        clk;
  logic        rst;
  logic [12:0] v;
  logic [15:0] sv;

  int n_chk;
  int n_pass;

  sine_rom dut (
    .clk(clk),
    .rst(rst),
    .v  (v),
    .sv (sv)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int ref_sine(input int k);
    real a;
    a = 3.14159265358979323846 * $itor(k) / 16384.0;
    return $rtoi(32767.0 * $sin(a) + 0.5);
  endfunction

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Caller sits at posedge+1; result is visible at the next posedge+1.
  task automatic apply(input int k);
    v = 13'(k);
    @(posedge clk);
    #1;
  endtask

  int  prev;
  int  cur;
  int  r_a;
  int  r_b;
  int  k;
  real s;

  initial begin
    n_chk  = 0;
    n_pass = 0;
    rst    = 1'b0;
    v      = 13'd4096;
    #1 rst = 1'b1;
    #1 chk("rst_async", int'(sv), 0);
    @(posedge clk); #1 chk("rst_hold0", int'(sv), 0);
    @(posedge clk); #1 chk("rst_hold1", int'(sv), 0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1 chk("rst_first", int'(sv), 23170);

    apply(0);    chk("key_0",    int'(sv), 0);
    apply(2048); chk("key_2048", int'(sv), 12539);
    apply(4096); chk("key_4096", int'(sv), 23170);
    apply(6144); chk("key_6144", int'(sv), 30273);
    apply(8191); chk("key_8191", int'(sv), 32767);

    prev = 0;
    for (int i = 0; i < 8192; i++) begin
      apply(i);
      cur = int'(sv);
      chk("sweep", cur, ref_sine(i));
      chk("sweep_msb", int'(sv[15]), 0);
      if (i > 0) chk("sweep_mono", int'(cur >= prev), 1);
      prev = cur;
    end

    // Before the edge the old value must still be held.
    for (int i = 0; i < 20; i++) begin
      k = (i % 2 == 0) ? 0 : 8191;
      v = 13'(k);
      #1 chk("alt_stale", int'(sv), ref_sine(8191 - k));
      @(posedge clk); #1;
      chk("alt_new", int'(sv), ref_sine(k));
    end

    apply(100);  r_a = int'(sv); chk("fold_100", r_a, ref_sine(100));
    apply(8091); r_b = int'(sv); chk("fold_8091", r_b, ref_sine(8091));
    s = ($itor(r_a) * $itor(r_a) + $itor(r_b) * $itor(r_b))
        / (32767.0 * 32767.0);
    chk("fold_pyth", int'((s - 1.0 < 1.0e-3) && (1.0 - s < 1.0e-3)), 1);

    apply(5000); chk("mid_pre", int'(sv), ref_sine(5000));
    #2 rst = 1'b1;
    #1 chk("mid_async", int'(sv), 0);
    @(posedge clk); #1 chk("mid_hold", int'(sv), 0);
    @(negedge clk) begin
      rst = 1'b0;
      v   = 13'd5001;
    end
    @(posedge clk); #1 chk("mid_resume", int'(sv), ref_sine(5001));
    apply(5002); chk("mid_next", int'(sv), ref_sine(5002));

    for (int i = 0; i < 300; i++) begin
      k = int'($urandom_range(8191, 0));
      apply(k);
      chk("rand", int'(sv), ref_sine(k));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
